// File: rtl/flash_timer_gen.sv
// Programmable prescaled tick timer with one-shot/periodic modes and a flash square wave.
// done is registered and fires on the expiry edge; there is no backpressure; stop > start > expiry.
module flash_timer_gen #(
    parameter int PRESCALE = 50_000,
    parameter int CNT_W    = 16
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] period,
    output logic             busy,
    output logic             done,
    output logic             flash
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             flash_q, flash_d;

    logic tick;
    logic expire;

    assign tick   = (state_q == COUNTING) && (pre_q == PRE_LAST);
    // period_q is never 0, so period_q-1 cannot underflow.
    assign expire = tick && (cnt_q == (period_q - CNT_W'(1)));

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        flash_d  = flash_q;

        if (stop) begin
            if (state_q == COUNTING) begin
                state_d = IDLE;
                flash_d = 1'b0;
            end
        end else if (start) begin
            period_d = (period == '0) ? CNT_W'(1) : period;
            mode_d   = periodic;
            pre_d    = '0;
            cnt_d    = '0;
            flash_d  = 1'b0;
            state_d  = COUNTING;
        end else if (state_q == COUNTING) begin
            if (tick) begin
                pre_d = '0;
                if (expire) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (mode_q) begin
                        flash_d = ~flash_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            flash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            flash_q  <= flash_d;
        end
    end

    assign busy  = (state_q == COUNTING);
    assign done  = done_q;
    assign flash = flash_q;

endmodule

// File: tb/tb_flash_timer_gen.sv
// Bench for flash_timer_gen: elapsed-cycle reference model checked every cycle plus directed literal checks.
module tb_flash_timer_gen;

    localparam int PS = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          periodic;
    logic [CW-1:0] period;
    logic          busy;
    logic          done;
    logic          flash;

    int n_checks = 0;
    int n_fail   = 0;

    flash_timer_gen #(.PRESCALE(PS), .CNT_W(CW)) dut (
        .CLK_50MHZ(clk),
        .RST      (rst_n),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
        .busy     (busy),
        .done     (done),
        .flash    (flash)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: count cycles elapsed since the accepted start; expiry whenever
    // that count is a multiple of period*PRESCALE.
    bit m_active = 1'b0;
    bit m_mode   = 1'b0;
    bit m_done   = 1'b0;
    bit m_flash  = 1'b0;
    int m_k      = 0;
    int m_len    = PS;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_mode   <= 1'b0;
            m_done   <= 1'b0;
            m_flash  <= 1'b0;
            m_k      <= 0;
        end else begin
            m_done <= 1'b0;
            if (stop) begin
                if (m_active) begin
                    m_active <= 1'b0;
                    m_flash  <= 1'b0;
                end
            end else if (start) begin
                m_active <= 1'b1;
                m_mode   <= periodic;
                m_len    <= ((period == 0) ? 1 : int'(period)) * PS;
                m_k      <= 0;
                m_flash  <= 1'b0;
            end else if (m_active) begin
                m_k <= m_k + 1;
                if ((m_k + 1) % m_len == 0) begin
                    m_done <= 1'b1;
                    if (m_mode) m_flash <= !m_flash;
                    else        m_active <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare all outputs against the model.
    task automatic step();
        @(negedge clk);
        n_checks++;
        if ({busy, done, flash} !== {m_active, m_done, m_flash}) begin
            n_fail++;
            $display("FAIL model at %0t: busy/done/flash got %b%b%b want %b%b%b",
                     $time, busy, done, flash, m_active, m_done, m_flash);
        end
    endtask

    // Called at a falling edge; returns at the falling edge just after E0.
    task automatic launch(input int p, input logic m);
        start    = 1'b1;
        period   = CW'(p);
        periodic = m;
        step();
        start = 1'b0;
    endtask

    logic seen_done;

    initial begin
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; period = '0;
        #1 rst_n = 1'b0;
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flash", flash, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // One-shot, period 3: done only after E0+12.
        launch(3, 1'b0);
        chk("s1_busy_e0", busy, 1'b1);
        for (int n = 1; n <= 14; n++) begin
            step();
            chk("s1_done", done, n == 12);
            if (n == 11 || n == 12) chk("s1_busy", busy, n < 12);
            if (n == 12) chk("s1_flash", flash, 1'b0);
        end

        // Periodic, period 2, stop sampled at E0+20.
        launch(2, 1'b1);
        for (int n = 1; n <= 25; n++) begin
            step();
            chk("s2_done", done, (n == 8) || (n == 16));
            if (n == 8 || n == 12) chk("s2_flash_hi", flash, 1'b1);
            if (n == 16)           chk("s2_flash_lo", flash, 1'b0);
            if (n == 20) begin
                chk("s2_stop_busy", busy, 1'b0);
                chk("s2_stop_flash", flash, 1'b0);
            end
            if (n == 19) stop = 1'b1;
            if (n == 20) stop = 1'b0;
        end

        // Zero period behaves as one tick.
        launch(0, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            step();
            chk("s3_done", done, n == 4);
            if (n == 4) chk("s3_busy", busy, 1'b0);
        end

        // Restart at E0+10 with period 2: single done after E0+18.
        launch(5, 1'b0);
        for (int n = 1; n <= 22; n++) begin
            if (n == 10) begin
                start  = 1'b1;
                period = CW'(2);
            end
            step();
            if (n == 10) start = 1'b0;
            chk("s4a_done", done, n == 18);
        end

        // Restart coinciding with the expiry edge at E0+4.
        launch(1, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            if (n == 4) start = 1'b1;
            step();
            if (n == 4) begin
                start = 1'b0;
                chk("s4b_busy", busy, 1'b1);
            end
            chk("s4b_done", done, n == 8);
        end

        // start+stop together in IDLE.
        start = 1'b1; stop = 1'b1; period = CW'(3);
        step();
        start = 1'b0; stop = 1'b0;
        chk("s5a_busy", busy, 1'b0);
        step();
        chk("s5a_busy2", busy, 1'b0);

        // stop on the expiry edge.
        launch(1, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            if (n == 4) stop = 1'b1;
            step();
            if (n == 4) begin
                stop = 1'b0;
                chk("s5b_busy", busy, 1'b0);
            end
            chk("s5b_done", done, 1'b0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            period   = CW'($urandom_range(0, 5));
            periodic = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        // Async reset while periodic count holds flash high.
        launch(1, 1'b1);
        for (int n = 1; n <= 5; n++) step();
        chk("s6_flash_pre", flash, 1'b1);
        chk("s6_busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_busy_rst", busy, 1'b0);
        chk("s6_done_rst", done, 1'b0);
        chk("s6_flash_rst", flash, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        chk("s6_no_done", seen_done, 1'b0);
        chk("s6_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
